cu_memfetch: RTL and testbench

Memory responder on the far side of the control unit's fetch/load/store requests. Holds instruction memory and data memory, accepts single-cycle request pulses from the CU (instruction fetch on `memfetch_start` with `Cu_PC`; data access with `Cu_MAR`/`Cu_MDR`), and returns results after a fixed wait-state latency with a one-cycle ready pulse. Sits between CU_top and the memory arrays; its `Fetch_ready`/`Fetch_IR` feed the CU's IR load and the decoder start.

---
 rtl/cu_memfetch_if.sv | 43 ++++
 rtl/cu_memfetch.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cu_memfetch.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_memfetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cu_memfetch_if
// Brief    : Fetch, data-access and program-load bus between the control unit
//            and its memory responder.
// Revision : 1.0
// ============================================================================
interface cu_memfetch_if #(
    parameter int IMEM_WORDS = 128
) ();
    logic                          memfetch_start;
    logic [31:0]                   Cu_PC;
    logic                          Fetch_ready;
    logic [31:0]                   Fetch_IR;
    logic                          fetch_err;
    logic                          mem_req;
    logic                          mem_we;
    logic [1:0]                    mem_size;
    logic                          mem_unsigned;
    logic [31:0]                   Cu_MAR;
    logic [31:0]                   Cu_MDR;
    logic                          mem_ready;
    logic [31:0]                   mem_rdata;
    logic                          mem_err;
    logic                          busy;
    logic                          prog_we;
    logic [$clog2(IMEM_WORDS)-1:0] prog_addr;
    logic [31:0]                   prog_data;

    modport master (
        output memfetch_start, Cu_PC, mem_req, mem_we, mem_size, mem_unsigned,
               Cu_MAR, Cu_MDR, prog_we, prog_addr, prog_data,
        input  Fetch_ready, Fetch_IR, fetch_err, mem_ready, mem_rdata, mem_err, busy
    );

    modport slave (
        input  memfetch_start, Cu_PC, mem_req, mem_we, mem_size, mem_unsigned,
               Cu_MAR, Cu_MDR, prog_we, prog_addr, prog_data,
        output Fetch_ready, Fetch_IR, fetch_err, mem_ready, mem_rdata, mem_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/cu_memfetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cu_memfetch
// Brief    : Instruction/data memory responder for the CU with fixed wait-state
//            latency. Optional next-word prefetch buffer: MEMFETCH_PREFETCH_EN.
// Revision : 1.0
// ============================================================================
module cu_memfetch #(
    parameter int IMEM_WORDS  = 128,
    parameter int DMEM_WORDS  = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic         soc_clk,
    input  logic         reset,
    cu_memfetch_if.slave bus
);
    localparam int          c_IAW        = $clog2(IMEM_WORDS);
    localparam int          c_DAW        = $clog2(DMEM_WORDS);
    localparam logic [31:0] c_IMEM_BYTES = 32'(4 * IMEM_WORDS);
    localparam logic [31:0] c_DMEM_BYTES = 32'(4 * DMEM_WORDS);
    localparam logic [2:0]  c_LAT_M1     = 3'(MEM_LATENCY - 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_DATA_WAIT  = 2'd1;
    localparam logic [1:0] S_FETCH_WAIT = 2'd2;

    logic [1:0]  r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        w_data_go, w_fetch_go, w_pend_set, w_pend_start;
    logic        w_data_done, w_fetch_done, w_hit;
    logic        r_pend_valid, r_fhit;
    logic [31:0] r_pend_pc, r_pc, r_addr, r_wdata;
    logic [1:0]  r_size;
    logic        r_we, r_uns;

    logic [31:0] r_imem [IMEM_WORDS];
    logic [31:0] r_dmem [DMEM_WORDS];

    logic        r_fetch_ready, r_fetch_err, r_mem_ready, r_mem_err;
    logic [31:0] r_fetch_ir, r_mem_rdata;

    logic        w_ferr, w_derr;
    logic [31:0] w_imem_rd, w_dword, w_load, w_wfull, w_pf_data;
    logic [15:0] w_lane;
    logic [3:0]  w_be;

    // ---------------- FSM ----------------
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_data_go    = 1'b0;
        w_fetch_go   = 1'b0;
        w_pend_set   = 1'b0;
        w_pend_start = 1'b0;
        w_data_done  = 1'b0;
        w_fetch_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A simultaneous fetch belongs to a younger instruction: park it.
                if (bus.mem_req) begin
                    w_data_go   = 1'b1;
                    w_pend_set  = bus.memfetch_start;
                    w_state_nxt = S_DATA_WAIT;
                    w_cnt_nxt   = c_LAT_M1;
                end else if (bus.memfetch_start) begin
                    w_fetch_go  = 1'b1;
                    w_state_nxt = S_FETCH_WAIT;
                    w_cnt_nxt   = w_hit ? 3'd0 : c_LAT_M1;
                end
            end
            S_DATA_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_data_done = 1'b1;
                    if (r_pend_valid) begin
                        w_pend_start = 1'b1;
                        w_state_nxt  = S_FETCH_WAIT;
                        w_cnt_nxt    = c_LAT_M1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_FETCH_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_fetch_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- access decode ----------------
    assign w_ferr = (r_pc[1:0] != 2'b00) || (r_pc >= c_IMEM_BYTES);
    assign w_derr = (r_size == 2'b11)
                 || ((r_size == 2'b01) && r_addr[0])
                 || ((r_size == 2'b10) && (r_addr[1:0] != 2'b00))
                 || (r_addr >= c_DMEM_BYTES);

    assign w_imem_rd = r_imem[r_pc[c_IAW+1:2]];
    assign w_dword   = r_dmem[r_addr[c_DAW+1:2]];
    assign w_lane    = 16'(w_dword >> {r_addr[1:0], 3'b000});

    always_comb begin
        w_load = w_dword;
        case (r_size)
            2'b00:   w_load = r_uns ? {24'd0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load = r_uns ? {16'd0, w_lane} : {{16{w_lane[15]}}, w_lane};
            default: w_load = w_dword;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b0000;
        w_wfull = r_wdata;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wfull = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wfull = {2{r_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge soc_clk) begin
        if (bus.prog_we) begin
            r_imem[bus.prog_addr] <= bus.prog_data;
        end
        if (!reset && w_data_done && r_we && !w_derr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_dmem[r_addr[c_DAW+1:2]][8*i +: 8] <= w_wfull[8*i +: 8];
                end
            end
        end
    end

    // ---------------- datapath / outputs ----------------
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_pend_valid  <= 1'b0;
            r_pend_pc     <= 32'd0;
            r_pc          <= 32'd0;
            r_fhit        <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_size        <= 2'b00;
            r_we          <= 1'b0;
            r_uns         <= 1'b0;
            r_fetch_ready <= 1'b0;
            r_fetch_ir    <= 32'd0;
            r_fetch_err   <= 1'b0;
            r_mem_ready   <= 1'b0;
            r_mem_rdata   <= 32'd0;
            r_mem_err     <= 1'b0;
        end else begin
            r_fetch_ready <= 1'b0;
            r_mem_ready   <= 1'b0;
            if (w_data_go) begin
                r_addr  <= bus.Cu_MAR;
                r_wdata <= bus.Cu_MDR;
                r_size  <= bus.mem_size;
                r_we    <= bus.mem_we;
                r_uns   <= bus.mem_unsigned;
            end
            if (w_pend_set) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= bus.Cu_PC;
            end
            if (w_fetch_go) begin
                r_pc   <= bus.Cu_PC;
                r_fhit <= w_hit;
            end
            if (w_pend_start) begin
                r_pc         <= r_pend_pc;
                r_fhit       <= 1'b0;
                r_pend_valid <= 1'b0;
            end
            if (w_data_done) begin
                r_mem_ready <= 1'b1;
                r_mem_err   <= w_derr;
                r_mem_rdata <= (w_derr || r_we) ? 32'd0 : w_load;
            end
            if (w_fetch_done) begin
                r_fetch_ready <= 1'b1;
                r_fetch_err   <= w_ferr;
                r_fetch_ir    <= w_ferr ? 32'd0 : (r_fhit ? w_pf_data : w_imem_rd);
            end
        end
    end

`ifdef MEMFETCH_PREFETCH_EN
    logic        r_pf_active, r_pf_valid;
    logic [2:0]  r_pf_cnt;
    logic [31:0] r_pf_pc, r_pf_addr, r_pf_data;
    logic        w_pf_next_ok;

    assign w_pf_next_ok = !w_ferr && ((r_pc + 32'd4) < c_IMEM_BYTES);
    assign w_hit        = r_pf_valid && (r_pf_addr == bus.Cu_PC) && !bus.prog_we;
    assign w_pf_data    = r_pf_data;

    // Starting a prefetch drops the old entry so a hit never races a buffer refill.
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_pf_active <= 1'b0;
            r_pf_valid  <= 1'b0;
            r_pf_cnt    <= 3'd0;
            r_pf_pc     <= 32'd0;
            r_pf_addr   <= 32'd0;
            r_pf_data   <= 32'd0;
        end else begin
            if (r_pf_active) begin
                if (r_pf_cnt == 3'd0) begin
                    r_pf_active <= 1'b0;
                    r_pf_valid  <= 1'b1;
                    r_pf_addr   <= r_pf_pc;
                    r_pf_data   <= r_imem[r_pf_pc[c_IAW+1:2]];
                end else begin
                    r_pf_cnt <= r_pf_cnt - 3'd1;
                end
            end
            if (w_fetch_go) begin
                r_pf_active <= 1'b0;
            end
            if (w_fetch_done && w_pf_next_ok) begin
                r_pf_active <= 1'b1;
                r_pf_valid  <= 1'b0;
                r_pf_cnt    <= c_LAT_M1;
                r_pf_pc     <= r_pc + 32'd4;
            end
            if (w_data_go || bus.prog_we) begin
                r_pf_active <= 1'b0;
                r_pf_valid  <= 1'b0;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_pf_data = 32'd0;
`endif

    assign bus.Fetch_ready = r_fetch_ready;
    assign bus.Fetch_IR    = r_fetch_ir;
    assign bus.fetch_err   = r_fetch_err;
    assign bus.mem_ready   = r_mem_ready;
    assign bus.mem_rdata   = r_mem_rdata;
    assign bus.mem_err     = r_mem_err;
    assign bus.busy        = (r_state != S_IDLE) || r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_cu_memfetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cu_memfetch
// Brief    : Directed self-checking bench for cu_memfetch (MEM_LATENCY = 2).
// Revision : 1.0
// ============================================================================
module tb_cu_memfetch;
    localparam logic [31:0] c_W0 = 32'h0050_0093;
    localparam logic [31:0] c_W1 = 32'h00A0_0113;
    localparam logic [31:0] c_W2 = 32'h0000_0013;
    localparam logic [31:0] c_W1_NEW = 32'h0030_0193;
`ifdef MEMFETCH_PREFETCH_EN
    localparam int c_PF_LAT = 1;
`else
    localparam int c_PF_LAT = 2;
`endif

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
        logic        err;
    } dvec_t;

    // Hand-computed: word DEADBEEF at 0x10, then byte A5 into 0x11 -> DEADA5EF.
    dvec_t c_dv [15] = '{
        '{1'b1, 2'b10, 1'b0, 32'h010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
        '{1'b0, 2'b00, 1'b0, 32'h013, 32'h0,         32'hFFFF_FFDE, 1'b0},
        '{1'b0, 2'b00, 1'b1, 32'h013, 32'h0,         32'h0000_00DE, 1'b0},
        '{1'b0, 2'b01, 1'b0, 32'h011, 32'h0,         32'h0000_0000, 1'b1},
        '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,         32'hDEAD_BEEF, 1'b0},
        '{1'b0, 2'b01, 1'b0, 32'h012, 32'h0,         32'hFFFF_DEAD, 1'b0},
        '{1'b1, 2'b00, 1'b0, 32'h011, 32'h1234_56A5, 32'h0000_0000, 1'b0},
        '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,         32'hDEAD_A5EF, 1'b0},
        '{1'b1, 2'b10, 1'b0, 32'h012, 32'h0000_0000, 32'h0000_0000, 1'b1},
        '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,         32'hDEAD_A5EF, 1'b0},
        '{1'b0, 2'b10, 1'b0, 32'h400, 32'h0,         32'h0000_0000, 1'b1},
        '{1'b0, 2'b11, 1'b0, 32'h010, 32'h0,         32'h0000_0000, 1'b1},
        '{1'b0, 2'b01, 1'b1, 32'h010, 32'h0,         32'h0000_A5EF, 1'b0},
        '{1'b1, 2'b01, 1'b0, 32'h3FE, 32'h0000_8001, 32'h0000_0000, 1'b0},
        '{1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0,         32'hFFFF_8001, 1'b0}
    };

    logic soc_clk = 1'b0;
    logic reset   = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    cu_memfetch_if #(.IMEM_WORDS(128)) bus ();

    cu_memfetch #(
        .IMEM_WORDS (128),
        .DMEM_WORDS (256),
        .MEM_LATENCY(2)
    ) dut (
        .soc_clk(soc_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 soc_clk = ~soc_clk;

    task automatic clear_inputs();
        bus.memfetch_start = 1'b0;
        bus.Cu_PC          = 32'd0;
        bus.mem_req        = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_size       = 2'b00;
        bus.mem_unsigned   = 1'b0;
        bus.Cu_MAR         = 32'd0;
        bus.Cu_MDR         = 32'd0;
        bus.prog_we        = 1'b0;
        bus.prog_addr      = '0;
        bus.prog_data      = 32'd0;
    endtask

    task automatic prog_write(input logic [6:0] a, input logic [31:0] d);
        @(negedge soc_clk);
        bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
        @(posedge soc_clk); #1;
        bus.prog_we = 1'b0;
    endtask

    task automatic issue_fetch(input logic [31:0] pc);
        @(negedge soc_clk);
        bus.memfetch_start = 1'b1; bus.Cu_PC = pc;
        @(posedge soc_clk); #1;
        bus.memfetch_start = 1'b0;
    endtask

    task automatic issue_data(input dvec_t v);
        @(negedge soc_clk);
        bus.mem_req = 1'b1; bus.mem_we = v.we; bus.mem_size = v.size;
        bus.mem_unsigned = v.uns; bus.Cu_MAR = v.addr; bus.Cu_MDR = v.data;
        @(posedge soc_clk); #1;
        bus.mem_req = 1'b0;
    endtask

    // Edges after the request edge until the ready pulse; 0 means none within budget.
    task automatic wait_fetch(output int lat);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge soc_clk); #1;
            if (bus.Fetch_ready) begin lat = n; break; end
        end
    endtask

    task automatic wait_mem(output int lat);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge soc_clk); #1;
            if (bus.mem_ready) begin lat = n; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge soc_clk);
        #1;
        n_checks++;
        if ({bus.Fetch_ready, bus.fetch_err, bus.mem_ready, bus.mem_err, bus.busy} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.Fetch_ready, bus.fetch_err, bus.mem_ready, bus.mem_err, bus.busy});
        else n_pass++;
        n_checks++;
        if (bus.Fetch_IR !== 32'd0) $display("FAIL reset_ir: got %h expected 00000000", bus.Fetch_IR);
        else n_pass++;
        n_checks++;
        if (bus.mem_rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 00000000", bus.mem_rdata);
        else n_pass++;
        reset = 1'b0;
        prog_write(7'd0, c_W0);
        prog_write(7'd1, c_W1);
        prog_write(7'd2, c_W2);
    endtask

    task automatic test_fetch();
        int lat;
        issue_fetch(32'h0);
        wait_fetch(lat);
        n_checks++;
        if (lat !== 2) $display("FAIL fetch0_lat: got %0d expected 2", lat); else n_pass++;
        n_checks++;
        if (bus.Fetch_IR !== c_W0) $display("FAIL fetch0_ir: got %h expected %h", bus.Fetch_IR, c_W0);
        else n_pass++;
        n_checks++;
        if (bus.fetch_err !== 1'b0) $display("FAIL fetch0_err: got %b expected 0", bus.fetch_err);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL fetch0_busy: got %b expected 0", bus.busy); else n_pass++;
        // Back-to-back: request in the ready cycle; a stretched pulse would show as lat 1.
        bus.memfetch_start = 1'b1; bus.Cu_PC = 32'h4;
        @(posedge soc_clk); #1;
        bus.memfetch_start = 1'b0;
        wait_fetch(lat);
        n_checks++;
        if (lat !== 2) $display("FAIL b2b_lat: got %0d expected 2", lat); else n_pass++;
        n_checks++;
        if (bus.Fetch_IR !== c_W1) $display("FAIL b2b_ir: got %h expected %h", bus.Fetch_IR, c_W1);
        else n_pass++;
    endtask

    task automatic test_fetch_err();
        logic [31:0] pcs [2];
        int lat;
        pcs[0] = 32'h202;
        pcs[1] = 32'h200;
        for (int i = 0; i < 2; i++) begin
            issue_fetch(pcs[i]);
            wait_fetch(lat);
            n_checks++;
            if (lat !== 2) $display("FAIL ferr%0d_lat: got %0d expected 2", i, lat); else n_pass++;
            n_checks++;
            if (bus.fetch_err !== 1'b1) $display("FAIL ferr%0d_err: got %b expected 1", i, bus.fetch_err);
            else n_pass++;
            n_checks++;
            if (bus.Fetch_IR !== 32'd0) $display("FAIL ferr%0d_ir: got %h expected 00000000", i, bus.Fetch_IR);
            else n_pass++;
        end
    endtask

    task automatic test_store_load();
        int lat;
        for (int i = 0; i < 15; i++) begin
            issue_data(c_dv[i]);
            wait_mem(lat);
            n_checks++;
            if (lat !== 2) $display("FAIL data%0d_lat: got %0d expected 2", i, lat); else n_pass++;
            n_checks++;
            if (bus.mem_rdata !== c_dv[i].rd)
                $display("FAIL data%0d_rdata: got %h expected %h", i, bus.mem_rdata, c_dv[i].rd);
            else n_pass++;
            n_checks++;
            if (bus.mem_err !== c_dv[i].err)
                $display("FAIL data%0d_err: got %b expected %b", i, bus.mem_err, c_dv[i].err);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        int mem_at = 0;
        int fet_at = 0;
        logic [3:0] busy_v = 4'b0;
        @(negedge soc_clk);
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'b10; bus.mem_unsigned = 1'b0;
        bus.Cu_MAR = 32'h10; bus.memfetch_start = 1'b1; bus.Cu_PC = 32'h4;
        @(posedge soc_clk); #1;
        bus.mem_req = 1'b0; bus.memfetch_start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge soc_clk); #1;
            if (bus.mem_ready && mem_at == 0) mem_at = n;
            if (bus.Fetch_ready && fet_at == 0) fet_at = n;
            if (n <= 4) busy_v[n-1] = bus.busy;
            if (n == 2 && bus.mem_rdata !== 32'hDEAD_A5EF) begin
                n_checks++;
                $display("FAIL coll_rdata: got %h expected deada5ef", bus.mem_rdata);
            end else if (n == 2) begin
                n_checks++; n_pass++;
            end
        end
        n_checks++;
        if (mem_at !== 2) $display("FAIL coll_mem_lat: got %0d expected 2", mem_at); else n_pass++;
        n_checks++;
        if (fet_at !== 4) $display("FAIL coll_fetch_lat: got %0d expected 4", fet_at); else n_pass++;
        n_checks++;
        if (busy_v !== 4'b0111) $display("FAIL coll_busy: got %b expected 0111", busy_v); else n_pass++;
        n_checks++;
        if (bus.Fetch_IR !== c_W1) $display("FAIL coll_ir: got %h expected %h", bus.Fetch_IR, c_W1);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int lat;
        int seen = 0;
        dvec_t v;
        issue_fetch(32'h0);
        reset = 1'b1;
        @(posedge soc_clk); #1;
        reset = 1'b0;
        @(posedge soc_clk); #1;
        n_checks++;
        if ({bus.Fetch_ready, bus.fetch_err, bus.busy} !== 3'b000 || bus.Fetch_IR !== 32'd0)
            $display("FAIL rst_mid_outputs: got rdy/err/busy %b ir %h expected 000 00000000",
                     {bus.Fetch_ready, bus.fetch_err, bus.busy}, bus.Fetch_IR);
        else n_pass++;
        for (int n = 0; n < 3; n++) begin
            @(posedge soc_clk); #1;
            if (bus.Fetch_ready) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL rst_mid_no_ready: got %0d pulses expected 0", seen); else n_pass++;
        issue_fetch(32'h0);
        wait_fetch(lat);
        n_checks++;
        if (lat !== 2 || bus.Fetch_IR !== c_W0)
            $display("FAIL rst_mid_refetch: got lat %0d ir %h expected lat 2 ir %h", lat, bus.Fetch_IR, c_W0);
        else n_pass++;
        // In-flight store cut by reset must leave the old word intact.
        v = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h0BAD_F00D, 32'h0, 1'b0};
        issue_data(v);
        wait_mem(lat);
        v = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 1'b0};
        issue_data(v);
        reset = 1'b1;
        @(posedge soc_clk); #1;
        reset = 1'b0;
        wait_mem(lat);
        n_checks++;
        if (lat !== 0) $display("FAIL rst_store_ready: got lat %0d expected none", lat); else n_pass++;
        v = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0};
        issue_data(v);
        wait_mem(lat);
        n_checks++;
        if (bus.mem_rdata !== 32'h0BAD_F00D)
            $display("FAIL rst_store_kept: got %h expected 0badf00d", bus.mem_rdata);
        else n_pass++;
    endtask

    task automatic test_fetch_latency();
        int lat;
        issue_fetch(32'h0);
        wait_fetch(lat);
        n_checks++;
        if (lat !== 2) $display("FAIL seq0_lat: got %0d expected 2", lat); else n_pass++;
        repeat (4) @(posedge soc_clk);
        issue_fetch(32'h4);
        wait_fetch(lat);
        n_checks++;
        if (lat !== c_PF_LAT) $display("FAIL seq4_lat: got %0d expected %0d", lat, c_PF_LAT); else n_pass++;
        n_checks++;
        if (bus.Fetch_IR !== c_W1) $display("FAIL seq4_ir: got %h expected %h", bus.Fetch_IR, c_W1);
        else n_pass++;
        issue_fetch(32'h0);
        wait_fetch(lat);
        repeat (4) @(posedge soc_clk);
        prog_write(7'd1, c_W1_NEW);
        issue_fetch(32'h4);
        wait_fetch(lat);
        n_checks++;
        if (lat !== 2) $display("FAIL prog4_lat: got %0d expected 2", lat); else n_pass++;
        n_checks++;
        if (bus.Fetch_IR !== c_W1_NEW) $display("FAIL prog4_ir: got %h expected %h", bus.Fetch_IR, c_W1_NEW);
        else n_pass++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch();
        test_fetch_err();
        test_store_load();
        test_collision();
        test_reset_midflight();
        test_fetch_latency();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
